i2s_adc_receiver: RTL and testbench

- Capture side of the audio codec serial interface. The existing song playback path drives the DAC direction; this block receives the ADC direction.
- Samples AUD_BCLK, AUD_ADCLRCK and AUD_ADCDAT in the 50 MHz domain and deserialises left and right words.
- Presents each complete stereo frame as parallel samples with a valid/ready handshake. Feeds microphone-based gameplay features such as strum-by-sound and level meters.

---
 rtl/i2s_adc_receiver_if.sv | 31 +++
 rtl/i2s_adc_receiver.sv | 164 ++++++++++++++++
 tb/tb_i2s_adc_receiver.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/i2s_adc_receiver_if.sv
// i2s_adc_receiver_if
//   Parallel-sample side of the ADC receiver. One stereo frame is offered
//   at a time.
//   left_sample  : last accepted left word
//   right_sample : last accepted right word
//   out_valid    : frame held, waiting for the consumer
//   out_ready    : consumer takes the frame in the cycle both are high
//   master = receiver (produces samples), slave = consumer.
`timescale 1ns/1ps
interface i2s_adc_receiver_if #(
    parameter int DATA_WIDTH = 16
);
    logic [DATA_WIDTH-1:0] left_sample;
    logic [DATA_WIDTH-1:0] right_sample;
    logic                  out_valid;
    logic                  out_ready;

    modport master (
        output left_sample,
        output right_sample,
        output out_valid,
        input  out_ready
    );

    modport slave (
        input  left_sample,
        input  right_sample,
        input  out_valid,
        output out_ready
    );
endinterface

// File: rtl/i2s_adc_receiver.sv
// i2s_adc_receiver
//   Capture side of the codec serial link. The BCLK, ADCLRCK and ADCDAT pins
//   are brought into the clk domain, the left and right words are
//   deserialised MSB first, and each complete left+right pair is offered
//   on the bus with a valid/ready handshake.
//   clk           : system clock, at least 8x BCLK
//   reset         : synchronous, active high
//   enable        : receiver run; low parks the FSM in IDLE
//   aud_bclk      : codec bit clock (asynchronous)
//   aud_adclrck   : channel select, 0 = left, 1 = right (asynchronous)
//   aud_adcdat    : serial data (asynchronous)
//   clear_overrun : one-cycle pulse, clears overrun
//   overrun       : sticky, a complete frame was dropped
//   bus           : left_sample / right_sample / out_valid / out_ready
//
//   state    | meaning
//   ---------+--------------------------------------------------------
//   IDLE     | waiting for an LRCK transition to align to a slot
//   SHIFT    | shifting data bits of the current slot into shreg
//   HOLD     | word committed, ignoring the rest of the slot
`timescale 1ns/1ps
module i2s_adc_receiver #(
    parameter int DATA_WIDTH = 16,
    parameter int I2S_MODE   = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    input  logic aud_bclk,
    input  logic aud_adclrck,
    input  logic aud_adcdat,
    input  logic clear_overrun,
    output logic overrun,
    i2s_adc_receiver_if.master bus
);

    localparam int CW = $clog2(DATA_WIDTH + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DATA_WIDTH - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_HOLD  = 2'd2;

    // [1:0] form the two-flop synchroniser, [2] is the previous value.
    // LRCK and DAT get the same depth so they line up with bclk_rise.
    logic [2:0] bclk_sr;
    logic [2:0] lr_sr;
    logic [2:0] dat_sr;
    logic       bclk_rise;

    logic       lr_q;
    logic [1:0] state;
    logic [CW-1:0] cnt;
    logic [DATA_WIDTH-2:0] shreg;
    logic       chan;
    logic       got_left;
    logic [DATA_WIDTH-1:0] hold_left;

    logic [DATA_WIDTH-1:0] left_q;
    logic [DATA_WIDTH-1:0] right_q;
    logic       valid_q;
    logic       overrun_q;

    logic       lr_s;
    logic       dat_s;
    logic       lr_edge;
    logic       shift_bit;
    logic [DATA_WIDTH-1:0] word;

    assign lr_s      = lr_sr[2];
    assign dat_s     = dat_sr[2];
    assign lr_edge   = bclk_rise && (lr_s != lr_q);
    assign shift_bit = (state == ST_SHIFT) && bclk_rise && !lr_edge;
    assign word      = {shreg, dat_s};

    assign bus.left_sample  = left_q;
    assign bus.right_sample = right_q;
    assign bus.out_valid    = valid_q;
    assign overrun          = overrun_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            bclk_sr   <= '0;
            lr_sr     <= '0;
            dat_sr    <= '0;
            bclk_rise <= 1'b0;
            lr_q      <= 1'b0;
        end else begin
            bclk_sr   <= {bclk_sr[1:0], aud_bclk};
            lr_sr     <= {lr_sr[1:0], aud_adclrck};
            dat_sr    <= {dat_sr[1:0], aud_adcdat};
            bclk_rise <= bclk_sr[1] && !bclk_sr[2];
            // Track LRCK even while disabled so re-enable aligns on a real edge.
            if (bclk_rise) begin
                lr_q <= lr_s;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            shreg     <= '0;
            chan      <= 1'b0;
            got_left  <= 1'b0;
            hold_left <= '0;
            left_q    <= '0;
            right_q   <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            if (clear_overrun) begin
                overrun_q <= 1'b0;
            end
            if (valid_q && bus.out_ready) begin
                valid_q <= 1'b0;
            end

            if (!enable) begin
                state    <= ST_IDLE;
                cnt      <= '0;
                shreg    <= '0;
                got_left <= 1'b0;
            end else if (lr_edge) begin
                chan  <= lr_s;
                state <= ST_SHIFT;
                // An edge while still shifting means the slot was short.
                if (state == ST_SHIFT) begin
                    got_left <= 1'b0;
                end
                if (I2S_MODE != 0) begin
                    // Standard I2S: this bit still belongs to the previous slot.
                    cnt   <= '0;
                    shreg <= '0;
                end else begin
                    cnt   <= CW'(1);
                    shreg <= {{(DATA_WIDTH-2){1'b0}}, dat_s};
                end
            end else if (shift_bit) begin
                shreg <= word[DATA_WIDTH-2:0];
                cnt   <= cnt + 1'b1;
                if (cnt == CNT_LAST) begin
                    state <= ST_HOLD;
                    if (!chan) begin
                        hold_left <= word;
                        got_left  <= 1'b1;
                    end else if (got_left) begin
                        got_left <= 1'b0;
                        if (!valid_q || bus.out_ready) begin
                            left_q  <= hold_left;
                            right_q <= word;
                            valid_q <= 1'b1;
                        end else begin
                            // Set is ordered after the clear so it wins.
                            overrun_q <= 1'b1;
                        end
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_i2s_adc_receiver.sv
`timescale 1ns/1ps
module tb_i2s_adc_receiver;

    logic clk;
    logic reset;
    logic en1, en0;
    logic bclk, lrck;
    logic dat1, dat0;
    logic clr1, clr0;
    logic ovr1, ovr0;

    int checks = 0;
    int errors = 0;

    i2s_adc_receiver_if #(.DATA_WIDTH(16)) bus1 ();
    i2s_adc_receiver_if #(.DATA_WIDTH(16)) bus0 ();

    i2s_adc_receiver #(.DATA_WIDTH(16), .I2S_MODE(1)) dut1 (
        .clk(clk), .reset(reset), .enable(en1),
        .aud_bclk(bclk), .aud_adclrck(lrck), .aud_adcdat(dat1),
        .clear_overrun(clr1), .overrun(ovr1), .bus(bus1)
    );

    i2s_adc_receiver #(.DATA_WIDTH(16), .I2S_MODE(0)) dut0 (
        .clk(clk), .reset(reset), .enable(en0),
        .aud_bclk(bclk), .aud_adclrck(lrck), .aud_adcdat(dat0),
        .clear_overrun(clr0), .overrun(ovr0), .bus(bus0)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        bit          mode;   // 1 = I2S instance, 0 = left-justified instance
        logic [15:0] lw;
        logic [15:0] rw;
        int          act;    // 1 = latency check on the last right bit
        bit          ack;
        bit          clr;
        logic [15:0] el;
        logic [15:0] er;
        logic        ev;
        logic        eo;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // One BCLK period of 16 clk: data/LRCK change on the falling edge.
    // act 1: check out_valid 3 and 4 clk edges after this rising edge.
    // act 2: raise out_ready only in the cycle the frame completes.
    task automatic send_bit(input logic lr, input logic d1, input logic d0, input int act);
        bclk = 1'b0;
        lrck = lr;
        dat1 = d1;
        dat0 = d0;
        repeat (8) @(negedge clk);
        bclk = 1'b1;
        if (act == 0) begin
            repeat (8) @(negedge clk);
        end else begin
            repeat (3) @(posedge clk);
            #1;
            if (act == 1) check("latency_edge3_valid", 32'(bus1.out_valid), 32'(0));
            else bus1.out_ready = 1'b1;
            @(posedge clk);
            #1;
            if (act == 1) check("latency_edge4_valid", 32'(bus1.out_valid), 32'(1));
            else bus1.out_ready = 1'b0;
            repeat (5) @(negedge clk);
        end
    endtask

    // Bits first..last-1 of a 32-bit slot, encoded for both framing modes.
    task automatic send_slot(input logic lr, input logic [15:0] w, input int first,
                             input int last, input int act);
        logic d1, d0;
        for (int i = first; i < last; i++) begin
            d1 = (i >= 1 && i <= 16) ? w[16 - i] : 1'b0;
            d0 = (i < 16) ? w[15 - i] : 1'b0;
            send_bit(lr, d1, d0, (i == 16) ? act : 0);
        end
    endtask

    task automatic send_frame(input logic [15:0] l, input logic [15:0] r, input int act);
        send_slot(1'b0, l, 0, 32, 0);
        send_slot(1'b1, r, 0, 32, act);
    endtask

    task automatic check_out(input bit mode, input string tag, input logic [15:0] el,
                             input logic [15:0] er, input logic ev, input logic eo);
        if (mode) begin
            check({tag, "_left"},    32'(bus1.left_sample),  32'(el));
            check({tag, "_right"},   32'(bus1.right_sample), 32'(er));
            check({tag, "_valid"},   32'(bus1.out_valid),    32'(ev));
            check({tag, "_overrun"}, 32'(ovr1),              32'(eo));
        end else begin
            check({tag, "_left"},    32'(bus0.left_sample),  32'(el));
            check({tag, "_right"},   32'(bus0.right_sample), 32'(er));
            check({tag, "_valid"},   32'(bus0.out_valid),    32'(ev));
            check({tag, "_overrun"}, 32'(ovr0),              32'(eo));
        end
    endtask

    task automatic pulse_ready(input bit mode, input string tag);
        @(negedge clk);
        if (mode) bus1.out_ready = 1'b1; else bus0.out_ready = 1'b1;
        @(negedge clk);
        if (mode) bus1.out_ready = 1'b0; else bus0.out_ready = 1'b0;
        if (mode) check({tag, "_ack_valid"}, 32'(bus1.out_valid), 32'(0));
        else      check({tag, "_ack_valid"}, 32'(bus0.out_valid), 32'(0));
    endtask

    task automatic pulse_clear(input bit mode, input string tag);
        @(negedge clk);
        if (mode) clr1 = 1'b1; else clr0 = 1'b1;
        @(negedge clk);
        clr1 = 1'b0;
        clr0 = 1'b0;
        if (mode) check({tag, "_clr_overrun"}, 32'(ovr1), 32'(0));
        else      check({tag, "_clr_overrun"}, 32'(ovr0), 32'(0));
    endtask

    task automatic run_vectors(input int lo, input int hi);
        string tag;
        for (int i = lo; i <= hi; i++) begin
            tag = $sformatf("v%0d", i);
            send_frame(vecs[i].lw, vecs[i].rw, vecs[i].act);
            check_out(vecs[i].mode, tag, vecs[i].el, vecs[i].er, vecs[i].ev, vecs[i].eo);
            if (vecs[i].ack) pulse_ready(vecs[i].mode, tag);
            if (vecs[i].clr) pulse_clear(vecs[i].mode, tag);
        end
    endtask

    initial begin
        //        mode lw        rw        act ack clr el        er        ev    eo
        vecs[0] = '{1'b1, 16'h1234, 16'hABCD, 1, 1'b1, 1'b0, 16'h1234, 16'hABCD, 1'b1, 1'b0};
        vecs[1] = '{1'b1, 16'h8000, 16'h7FFF, 0, 1'b1, 1'b0, 16'h8000, 16'h7FFF, 1'b1, 1'b0};
        vecs[2] = '{1'b1, 16'h1111, 16'h2222, 0, 1'b0, 1'b0, 16'h1111, 16'h2222, 1'b1, 1'b0};
        vecs[3] = '{1'b1, 16'h3333, 16'h4444, 0, 1'b0, 1'b1, 16'h1111, 16'h2222, 1'b1, 1'b1};
        vecs[4] = '{1'b0, 16'h00FF, 16'hFF00, 0, 1'b1, 1'b0, 16'h00FF, 16'hFF00, 1'b1, 1'b0};
        vecs[5] = '{1'b0, 16'h8001, 16'h7FFE, 0, 1'b0, 1'b0, 16'h8001, 16'h7FFE, 1'b1, 1'b0};
        vecs[6] = '{1'b0, 16'hA5A5, 16'h5A5A, 0, 1'b0, 1'b1, 16'h8001, 16'h7FFE, 1'b1, 1'b1};

        reset = 1'b1;
        en1 = 1'b1;
        en0 = 1'b0;
        bclk = 1'b0;
        lrck = 1'b0;
        dat1 = 1'b0;
        dat0 = 1'b0;
        clr1 = 1'b0;
        clr0 = 1'b0;
        bus1.out_ready = 1'b0;
        bus0.out_ready = 1'b0;
        repeat (4) @(negedge clk);
        check_out(1'b1, "reset", 16'h0, 16'h0, 1'b0, 1'b0);
        reset = 1'b0;

        // Lead-in right slot: the receiver aligns on it and discards the word.
        send_slot(1'b1, 16'hDEAD, 0, 32, 0);

        // Basic frame with latency, handshake, overrun and clear.
        run_vectors(0, 3);

        // Frame completes in the very cycle the consumer takes the held one.
        send_frame(16'h5555, 16'h6666, 2);
        check_out(1'b1, "simul", 16'h5555, 16'h6666, 1'b1, 1'b0);
        pulse_ready(1'b1, "simul");

        // Short left slot: LRCK toggles after 10 bits, no frame is produced.
        send_slot(1'b0, 16'h7777, 0, 10, 0);
        send_slot(1'b1, 16'h8888, 0, 32, 0);
        check("short_valid", 32'(bus1.out_valid), 32'(0));
        check("short_left", 32'(bus1.left_sample), 32'h5555);

        // Enable dropped in the middle of a left word.
        send_slot(1'b0, 16'hC3C3, 0, 12, 0);
        en1 = 1'b0;
        repeat (20) @(negedge clk);
        en1 = 1'b1;
        send_slot(1'b0, 16'hC3C3, 12, 32, 0);
        send_slot(1'b1, 16'h3C3C, 0, 32, 0);
        check("endrop_valid", 32'(bus1.out_valid), 32'(0));
        check("endrop_left", 32'(bus1.left_sample), 32'h5555);
        check("endrop_right", 32'(bus1.right_sample), 32'h6666);
        send_frame(16'h2468, 16'h1357, 0);
        check_out(1'b1, "resume", 16'h2468, 16'h1357, 1'b1, 1'b0);
        pulse_ready(1'b1, "resume");

        // Reset released in the middle of a right slot.
        send_slot(1'b0, 16'h9999, 0, 32, 0);
        send_slot(1'b1, 16'hAAAA, 0, 10, 0);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("midrst_valid", 32'(bus1.out_valid), 32'(0));
        check("midrst_left", 32'(bus1.left_sample), 32'(0));
        reset = 1'b0;
        send_slot(1'b1, 16'hAAAA, 10, 32, 0);
        check("midrst_discard_valid", 32'(bus1.out_valid), 32'(0));
        send_frame(16'h0A0A, 16'h0B0B, 0);
        check_out(1'b1, "midrst_first", 16'h0A0A, 16'h0B0B, 1'b1, 1'b0);

        // Left-justified instance.
        en1 = 1'b0;
        en0 = 1'b1;
        run_vectors(4, 6);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
